rtc_update_ctrl: RTL and testbench
==================================

RTC_UPDATE_CTRL -- requirements
Module: rtc_update_ctrl

Interface
REQ-001 SHALL have parameter C_SETTLE_CYCLES, default 4, giving the number of cycles waited after a gptp_vaild pulse before ack (range 1-15).
REQ-002 SHALL have parameter C_DEFAULT_INCREMENT, default 26'h0800000, giving the reset value of rtc_increment (8 ns/clk; 1 ns = 2^20).
REQ-003 SHALL have parameter C_USE_RTC_READY, default 0; when 1, the pulse is gated by rtc_ready.
REQ-004 SHALL have ports: rtc_clk in 1 clock; rtc_reset in 1 async active-low reset.
REQ-005 SHALL have ports: set_req in 1; set_nanosec in 32; set_sec in 32; set_epoch in 16; set_ack out 1. Together these load the base (syntonised) time.
REQ-006 SHALL have ports: ofs_req in 1; ofs_nanosec in 30; ofs_sec in 32; ofs_epoch in 16; ofs_ack out 1. Together these apply the offset.
REQ-007 SHALL have ports: inc_req in 1; inc_value in 26; inc_ack out 1. Together these apply a rate (increment) update.
REQ-008 SHALL have port upd_err out 1: a range error, valid only with an ack.
REQ-009 SHALL have port busy out 1: high when the FSM is not in IDLE.
REQ-010 SHALL have ports to the RTC: gptp_vaild out 1; gptp_sw out 1; syntonised_nanosec_field_r out 32; syntonised_sec_field_r out 32; syntonised_epoch_field_r out 16; nanosec_offset out 30; sec_offset out 32; epoch_offset out 16; rtc_increment out 26; rtc_ready in 1.

Function
REQ-011 SHALL implement states IDLE, LOAD, PULSE, SETTLE, ACK; all outputs SHALL be registered.
REQ-012 Handshake: the requester SHALL hold req high with data stable until its ack; ack SHALL be a one-cycle pulse; req SHALL be ignored in the ack cycle.
REQ-013 In IDLE, with any req high, SHALL grant by fixed priority set > ofs > inc, latch the grant and go to LOAD.
REQ-014 In LOAD, SHALL range-check the data: set_nanosec or ofs_nanosec > 999_999_999 sets the error flag, skips the output update and goes to ACK.
REQ-015 In LOAD with no error, SHALL register the granted data into its output group. Groups: set -> syntonised_*_r; ofs -> *_offset; inc -> rtc_increment.
REQ-016 From LOAD, an inc grant SHALL go to ACK; a set or ofs grant SHALL go to PULSE.
REQ-017 In PULSE, gptp_vaild SHALL be 1 for exactly one cycle, with gptp_sw = 1 for ofs and 0 for set.
REQ-018 If C_USE_RTC_READY = 1 and rtc_ready = 0, SHALL stay in PULSE with gptp_vaild = 0 until rtc_ready = 1; it then pulses once.
REQ-019 gptp_sw SHALL be 1 whenever gptp_vaild = 0.
REQ-020 SETTLE SHALL last exactly C_SETTLE_CYCLES cycles via a down-counter, then go to ACK.
REQ-021 In ACK, SHALL pulse the granted ack, drive upd_err = error flag, then go to IDLE; upd_err SHALL be 0 outside ACK.
REQ-022 Latency, with E0 the edge that samples req in IDLE: set/ofs ack SHALL be high in the cycle after edge E0+2+C_SETTLE_CYCLES (no rtc_ready stall); inc ack SHALL be high after E0+2; error ack SHALL be high after E0+2.
REQ-023 Data outputs SHALL hold their values between updates; offsets SHALL persist until the next ofs operation and SHALL NOT change during PULSE or SETTLE.
REQ-024 A set operation SHALL NOT modify the offset or increment outputs.
REQ-025 Requests arriving while busy SHALL wait; a req withdrawn mid-operation SHALL NOT abort the operation, and its ack SHALL still pulse.
REQ-026 Back-to-back: after ACK, the next grant SHALL be taken at the first IDLE edge; the minimum set-to-set spacing SHALL be C_SETTLE_CYCLES+3 cycles.

Reset
REQ-027 rtc_reset low SHALL asynchronously force IDLE with the following values:
- gptp_vaild = 0, gptp_sw = 1;
- all acks, upd_err and busy = 0;
- syntonised_*_r = 0 and all offsets = 0;
- rtc_increment = C_DEFAULT_INCREMENT.
REQ-028 Reset mid-operation SHALL discard the operation with no ack; release SHALL be sampled synchronously and the FSM SHALL be in IDLE on the first edge after release.

Verification
REQ-029 Set (1/2, N=4): set_req with set_nanosec = 500_000_000 and set_sec = 10 -> gptp_vaild = 1 and gptp_sw = 0 for one cycle, with the data stable; set_ack after E0+6; offsets unchanged.
REQ-030 Offset: ofs_req with ofs_nanosec = 300 and ofs_sec = 2 -> a single vaild pulse with sw = 1; nanosec_offset = 300 held after ack; upd_err = 0.
REQ-031 Simultaneous set/ofs/inc reqs -> served in order set, ofs, inc; three acks with no overlap; one vaild pulse each for set and ofs only.
REQ-032 Error: ofs_nanosec = 1_000_000_000 -> ofs_ack with upd_err = 1 after E0+2; no vaild pulse; offsets unchanged.
REQ-033 C_USE_RTC_READY = 1 with rtc_ready low for 5 cycles -> busy held, no vaild; a single pulse once ready rises.
REQ-034 Reset asserted during SETTLE -> no ack; all outputs at reset values, including rtc_increment = 26'h0800000.

Source files
------------

// File: rtl/rtc_update_ctrl.sv
// rtl/rtc_update_ctrl.sv - arbitrates set/offset/rate updates into the RTC with a gPTP valid pulse
module rtc_update_ctrl #(
  parameter int unsigned C_SETTLE_CYCLES     = 4,
  parameter logic [25:0] C_DEFAULT_INCREMENT = 26'h0800000,
  parameter bit          C_USE_RTC_READY     = 1'b0
) (
  input  logic        rtc_clk,
  input  logic        rtc_reset,

  input  logic        set_req,
  input  logic [31:0] set_nanosec,
  input  logic [31:0] set_sec,
  input  logic [15:0] set_epoch,
  output logic        set_ack,

  input  logic        ofs_req,
  input  logic [29:0] ofs_nanosec,
  input  logic [31:0] ofs_sec,
  input  logic [15:0] ofs_epoch,
  output logic        ofs_ack,

  input  logic        inc_req,
  input  logic [25:0] inc_value,
  output logic        inc_ack,

  output logic        upd_err,
  output logic        busy,

  output logic        gptp_vaild,
  output logic        gptp_sw,
  output logic [31:0] syntonised_nanosec_field_r,
  output logic [31:0] syntonised_sec_field_r,
  output logic [15:0] syntonised_epoch_field_r,
  output logic [29:0] nanosec_offset,
  output logic [31:0] sec_offset,
  output logic [15:0] epoch_offset,
  output logic [25:0] rtc_increment,
  input  logic        rtc_ready
);

  localparam logic [31:0] NS_MAX = 32'd999_999_999;
  // The pulse cycle already counts as the first settle cycle, so SETTLE holds for the rest.
  localparam logic [3:0]  SETTLE_LOAD = 4'(C_SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PULSE, S_SETTLE, S_ACK} state_t;
  typedef enum logic [1:0] {G_SET, G_OFS, G_INC} grant_t;

  state_t     state;
  state_t     next_state;
  grant_t     grant;
  logic       err_flag;
  logic [3:0] settle_cnt;

  logic       fire;
  logic       load_err;
  logic       set_go;
  logic       ofs_go;
  logic       inc_go;

  logic       vaild_d;
  logic       sw_d;
  logic       set_ack_d;
  logic       ofs_ack_d;
  logic       inc_ack_d;
  logic       upd_err_d;
  logic       busy_d;

  // A requester still holds req during its own ack cycle; masking keeps it from being re-granted.
  assign set_go = set_req && !set_ack;
  assign ofs_go = ofs_req && !ofs_ack;
  assign inc_go = inc_req && !inc_ack;

  assign fire = (C_USE_RTC_READY == 1'b0) || rtc_ready;

  assign load_err = ((grant == G_SET) && (set_nanosec > NS_MAX)) ||
                    ((grant == G_OFS) && ({2'b00, ofs_nanosec} > NS_MAX));

  // State register.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (set_go || ofs_go || inc_go) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_err || (grant == G_INC)) begin
          next_state = S_ACK;
        end else begin
          next_state = S_PULSE;
        end
      end
      S_PULSE: begin
        if (fire) begin
          next_state = (C_SETTLE_CYCLES <= 1) ? S_ACK : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == 4'd1) begin
          next_state = S_ACK;
        end
      end
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Grant latch, range-error flag and settle down-counter.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      grant      <= G_SET;
      err_flag   <= 1'b0;
      settle_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (set_go) begin
            grant    <= G_SET;
            err_flag <= 1'b0;
          end else if (ofs_go) begin
            grant    <= G_OFS;
            err_flag <= 1'b0;
          end else if (inc_go) begin
            grant    <= G_INC;
            err_flag <= 1'b0;
          end
        end
        S_LOAD:   err_flag <= load_err;
        S_PULSE: begin
          if (fire) begin
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Data groups load once in LOAD and hold until the next accepted update of the same group.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      syntonised_nanosec_field_r <= 32'd0;
      syntonised_sec_field_r     <= 32'd0;
      syntonised_epoch_field_r   <= 16'd0;
      nanosec_offset             <= 30'd0;
      sec_offset                 <= 32'd0;
      epoch_offset               <= 16'd0;
      rtc_increment              <= C_DEFAULT_INCREMENT;
    end else if ((state == S_LOAD) && !load_err) begin
      case (grant)
        G_SET: begin
          syntonised_nanosec_field_r <= set_nanosec;
          syntonised_sec_field_r     <= set_sec;
          syntonised_epoch_field_r   <= set_epoch;
        end
        G_OFS: begin
          nanosec_offset <= ofs_nanosec;
          sec_offset     <= ofs_sec;
          epoch_offset   <= ofs_epoch;
        end
        G_INC:   rtc_increment <= inc_value;
        default: ;
      endcase
    end
  end

  // Output decode; pulses and acks are registered one cycle after the state that produces them.
  always_comb begin
    vaild_d   = (state == S_PULSE) && fire;
    sw_d      = vaild_d ? (grant == G_OFS) : 1'b1;
    set_ack_d = (state == S_ACK) && (grant == G_SET);
    ofs_ack_d = (state == S_ACK) && (grant == G_OFS);
    inc_ack_d = (state == S_ACK) && (grant == G_INC);
    upd_err_d = (state == S_ACK) && err_flag;
    busy_d    = (next_state != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      gptp_vaild <= 1'b0;
      gptp_sw    <= 1'b1;
      set_ack    <= 1'b0;
      ofs_ack    <= 1'b0;
      inc_ack    <= 1'b0;
      upd_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gptp_vaild <= vaild_d;
      gptp_sw    <= sw_d;
      set_ack    <= set_ack_d;
      ofs_ack    <= ofs_ack_d;
      inc_ack    <= inc_ack_d;
      upd_err    <= upd_err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_rtc_update_ctrl.sv
// tb/tb_rtc_update_ctrl.sv - directed self-checking bench for rtc_update_ctrl
module tb_rtc_update_ctrl;

  logic        rtc_clk = 1'b0;
  logic        rtc_reset;
  logic        set_req, ofs_req, inc_req;
  logic [31:0] set_nanosec, set_sec, ofs_sec;
  logic [15:0] set_epoch, ofs_epoch;
  logic [29:0] ofs_nanosec;
  logic [25:0] inc_value;
  logic        rtc_ready;

  logic        set_ack, ofs_ack, inc_ack, upd_err, busy, gptp_vaild, gptp_sw;
  logic [31:0] syn_ns, syn_sec, sec_ofs;
  logic [15:0] syn_ep, ep_ofs;
  logic [29:0] ns_ofs;
  logic [25:0] rtc_inc;

  logic        r_set_req, r_ofs_req, r_inc_req;
  logic        r_set_ack, r_ofs_ack, r_inc_ack, r_upd_err, r_busy, r_vaild, r_sw;
  logic [31:0] r_syn_ns, r_syn_sec, r_sec_ofs;
  logic [15:0] r_syn_ep, r_ep_ofs;
  logic [29:0] r_ns_ofs;
  logic [25:0] r_inc;

  int checks = 0;
  int errors = 0;

  always #5 rtc_clk = ~rtc_clk;

  rtc_update_ctrl dut (
    .rtc_clk(rtc_clk), .rtc_reset(rtc_reset),
    .set_req(set_req), .set_nanosec(set_nanosec), .set_sec(set_sec), .set_epoch(set_epoch), .set_ack(set_ack),
    .ofs_req(ofs_req), .ofs_nanosec(ofs_nanosec), .ofs_sec(ofs_sec), .ofs_epoch(ofs_epoch), .ofs_ack(ofs_ack),
    .inc_req(inc_req), .inc_value(inc_value), .inc_ack(inc_ack),
    .upd_err(upd_err), .busy(busy), .gptp_vaild(gptp_vaild), .gptp_sw(gptp_sw),
    .syntonised_nanosec_field_r(syn_ns), .syntonised_sec_field_r(syn_sec), .syntonised_epoch_field_r(syn_ep),
    .nanosec_offset(ns_ofs), .sec_offset(sec_ofs), .epoch_offset(ep_ofs),
    .rtc_increment(rtc_inc), .rtc_ready(rtc_ready)
  );

  rtc_update_ctrl #(.C_USE_RTC_READY(1'b1)) dut_rdy (
    .rtc_clk(rtc_clk), .rtc_reset(rtc_reset),
    .set_req(r_set_req), .set_nanosec(set_nanosec), .set_sec(set_sec), .set_epoch(set_epoch), .set_ack(r_set_ack),
    .ofs_req(r_ofs_req), .ofs_nanosec(ofs_nanosec), .ofs_sec(ofs_sec), .ofs_epoch(ofs_epoch), .ofs_ack(r_ofs_ack),
    .inc_req(r_inc_req), .inc_value(inc_value), .inc_ack(r_inc_ack),
    .upd_err(r_upd_err), .busy(r_busy), .gptp_vaild(r_vaild), .gptp_sw(r_sw),
    .syntonised_nanosec_field_r(r_syn_ns), .syntonised_sec_field_r(r_syn_sec), .syntonised_epoch_field_r(r_syn_ep),
    .nanosec_offset(r_ns_ofs), .sec_offset(r_sec_ofs), .epoch_offset(r_ep_ofs),
    .rtc_increment(r_inc), .rtc_ready(rtc_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rtc_clk);
  endtask

  // Raises one request at a negedge; k counts negedges after E0 (k=0 is right after E0).
  task automatic run_op(input int which, output int ack_k, output int v_cnt, output int v_k,
                        output logic v_sw, output logic err, output int sw_bad);
    logic a;
    ack_k = -1; v_cnt = 0; v_k = -1; v_sw = 1'b1; err = 1'b0; sw_bad = 0;
    case (which)
      0:       set_req = 1'b1;
      1:       ofs_req = 1'b1;
      default: inc_req = 1'b1;
    endcase
    for (int k = 0; k < 40 && ack_k < 0; k++) begin
      @(negedge rtc_clk);
      if (gptp_vaild) begin
        v_cnt++; v_k = k; v_sw = gptp_sw;
      end else if (!gptp_sw) begin
        sw_bad++;
      end
      a = (which == 0) ? set_ack : (which == 1) ? ofs_ack : inc_ack;
      if (a) begin
        ack_k = k; err = upd_err;
        set_req = 1'b0; ofs_req = 1'b0; inc_req = 1'b0;
      end
    end
  endtask

  int   ack_k, v_cnt, v_k, sw_bad, sk, ok, ik, vc, ovl, acks, bb;
  logic v_sw, err;

  initial begin
    rtc_reset = 1'b0;
    set_req = 0; ofs_req = 0; inc_req = 0;
    r_set_req = 0; r_ofs_req = 0; r_inc_req = 0;
    set_nanosec = 0; set_sec = 0; set_epoch = 0;
    ofs_nanosec = 0; ofs_sec = 0; ofs_epoch = 0;
    inc_value = 0; rtc_ready = 0;
    cyc(2);
    chk("rst_vaild", gptp_vaild, 0);
    chk("rst_sw", gptp_sw, 1);
    chk("rst_acks", {set_ack, ofs_ack, inc_ack, upd_err, busy}, 0);
    chk("rst_syn_ns", syn_ns, 0);
    chk("rst_ofs", {ns_ofs, sec_ofs, ep_ofs}, 0);
    chk("rst_inc", rtc_inc, 26'h0800000);
    rtc_reset = 1'b1;
    cyc(1);

    // Set: vaild two edges after E0, ack after E0+2+N.
    set_nanosec = 32'd500_000_000; set_sec = 32'd10; set_epoch = 16'd3;
    run_op(0, ack_k, v_cnt, v_k, v_sw, err, sw_bad);
    chk("set_ack_k", ack_k, 6);
    chk("set_vcnt", v_cnt, 1);
    chk("set_vk", v_k, 2);
    chk("set_sw", v_sw, 0);
    chk("set_sw_idle", sw_bad, 0);
    chk("set_err", err, 0);
    chk("set_ns", syn_ns, 500_000_000);
    chk("set_sec", syn_sec, 10);
    chk("set_ep", syn_ep, 3);
    chk("set_ofs_kept", {ns_ofs, sec_ofs, ep_ofs}, 0);
    chk("set_inc_kept", rtc_inc, 26'h0800000);
    cyc(1);
    chk("set_ack_1cyc", set_ack, 0);
    chk("set_idle", busy, 0);

    // Offset.
    ofs_nanosec = 30'd300; ofs_sec = 32'd2; ofs_epoch = 16'd0;
    run_op(1, ack_k, v_cnt, v_k, v_sw, err, sw_bad);
    chk("ofs_ack_k", ack_k, 6);
    chk("ofs_vcnt", v_cnt, 1);
    chk("ofs_sw", v_sw, 1);
    chk("ofs_err", err, 0);
    cyc(3);
    chk("ofs_ns", ns_ofs, 300);
    chk("ofs_sec", sec_ofs, 2);
    chk("ofs_syn_kept", syn_ns, 500_000_000);

    // Rate update: no pulse, ack after E0+2.
    inc_value = 26'h0810000;
    run_op(2, ack_k, v_cnt, v_k, v_sw, err, sw_bad);
    chk("inc_ack_k", ack_k, 2);
    chk("inc_vcnt", v_cnt, 0);
    chk("inc_val", rtc_inc, 26'h0810000);
    chk("inc_ofs_kept", ns_ofs, 300);
    cyc(1);

    // Range error on offset: 1e9 rejected.
    ofs_nanosec = 30'd1_000_000_000; ofs_sec = 32'd99;
    run_op(1, ack_k, v_cnt, v_k, v_sw, err, sw_bad);
    chk("err_ack_k", ack_k, 2);
    chk("err_flag", err, 1);
    chk("err_vcnt", v_cnt, 0);
    chk("err_ofs_kept", {ns_ofs, sec_ofs}, {30'd300, 32'd2});
    cyc(1);
    chk("err_clr", upd_err, 0);

    // Boundary: 999_999_999 accepted on set.
    set_nanosec = 32'd999_999_999;
    run_op(0, ack_k, v_cnt, v_k, v_sw, err, sw_bad);
    chk("bnd_err", err, 0);
    chk("bnd_ack_k", ack_k, 6);
    chk("bnd_ns", syn_ns, 999_999_999);
    cyc(1);

    // Simultaneous requests: set, then ofs, then inc.
    set_nanosec = 32'd7; set_sec = 32'd1; ofs_nanosec = 30'd11; ofs_sec = 32'd0; inc_value = 26'h07F0000;
    set_req = 1; ofs_req = 1; inc_req = 1;
    sk = -1; ok = -1; ik = -1; vc = 0; ovl = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge rtc_clk);
      if (gptp_vaild) vc++;
      if ((set_ack && ofs_ack) || (set_ack && inc_ack) || (ofs_ack && inc_ack)) ovl++;
      if (set_ack) begin sk = k; set_req = 0; end
      if (ofs_ack) begin ok = k; ofs_req = 0; end
      if (inc_ack) begin ik = k; inc_req = 0; end
    end
    chk("sim_set_k", sk, 6);
    chk("sim_ofs_k", ok, 13);
    chk("sim_inc_k", ik, 16);
    chk("sim_vcnt", vc, 2);
    chk("sim_overlap", ovl, 0);
    chk("sim_data", {syn_ns, ns_ofs, rtc_inc}, {32'd7, 30'd11, 26'h07F0000});

    // Request withdrawn after grant still completes.
    set_req = 1; sk = -1;
    @(negedge rtc_clk);
    set_req = 0;
    for (int k = 1; k < 20 && sk < 0; k++) begin
      @(negedge rtc_clk);
      if (set_ack) sk = k;
    end
    chk("wd_ack_k", sk, 6);
    cyc(1);

    // Reset during SETTLE: no ack, everything back to reset values.
    set_nanosec = 32'd123; set_req = 1; acks = 0;
    cyc(4);
    rtc_reset = 1'b0;
    #1;
    set_req = 0;
    chk("mr_vaild_sw", {gptp_vaild, gptp_sw}, 2'b01);
    chk("mr_acks", {set_ack, ofs_ack, inc_ack, upd_err, busy}, 0);
    chk("mr_syn", {syn_ns, syn_sec, syn_ep}, 0);
    chk("mr_ofs", {ns_ofs, sec_ofs, ep_ofs}, 0);
    chk("mr_inc", rtc_inc, 26'h0800000);
    for (int k = 0; k < 8; k++) begin
      @(negedge rtc_clk);
      if (k == 2) rtc_reset = 1'b1;
      if (set_ack || ofs_ack || inc_ack) acks++;
    end
    chk("mr_no_ack", acks, 0);
    chk("mr_idle", busy, 0);
    chk("mr_syn_kept", syn_ns, 0);
    inc_value = 26'h0801234;
    run_op(2, ack_k, v_cnt, v_k, v_sw, err, sw_bad);
    chk("mr_inc_ack_k", ack_k, 2);
    chk("mr_inc_val", rtc_inc, 26'h0801234);
    cyc(1);

    // rtc_ready gating: stall in PULSE, then a single pulse.
    set_nanosec = 32'd42; rtc_ready = 0; r_set_req = 1;
    vc = 0; bb = 0; sk = -1; v_k = -1;
    for (int k = 0; k < 30 && sk < 0; k++) begin
      @(negedge rtc_clk);
      if (r_vaild) begin vc++; v_k = k; end
      if (k <= 6 && !r_busy) bb++;
      if (k == 6) begin
        chk("rdy_no_vaild", vc, 0);
        rtc_ready = 1;
      end
      if (r_set_ack) begin sk = k; r_set_req = 0; end
    end
    chk("rdy_busy", bb, 0);
    chk("rdy_vcnt", vc, 1);
    chk("rdy_vk", v_k, 7);
    chk("rdy_ack_k", sk, 11);
    chk("rdy_ns", r_syn_ns, 42);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
